// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared FSM state type, UART address and default sizing for the UART TX scheduler.
package uart_tx_sched_pkg;
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    localparam logic [31:0] UART_ADDR = 32'h1000_0000;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_BYTE_CYCLES = 8680;
endpackage

// File: rtl/uart_tx_sched_fifo.sv
// uart_tx_fifo: byte queue with wrap-around pointers; push is ignored while full, pop while empty.
module uart_tx_fifo
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     CLK,
    input  logic                     NRST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: queues CPU UART stores and issues them to the UART one byte every BYTE_CYCLES clocks.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int BYTE_CYCLES = DEF_BYTE_CYCLES
) (
    input  logic                   CLK,
    input  logic                   NRST,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   stall,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   uart_wr,
    output logic [7:0]             uart_dat
);
    state_t      state;
    logic [15:0] gap;
    logic [7:0]  head;
    logic        empty;
    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .NRST  (NRST),
        .push  (wr_en),
        .pop   (state == SEND),
        .din   (wr_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign stall = wr_en && full;
    assign busy  = state != IDLE || !empty;
    // SEND + (BYTE_CYCLES-2) GAP cycles + one IDLE cycle spaces strobes exactly BYTE_CYCLES apart.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state    <= IDLE;
            gap      <= '0;
            uart_wr  <= 1'b0;
            uart_dat <= 8'h00;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    state    <= SEND;
                    uart_wr  <= 1'b1;
                    uart_dat <= head;
                end
                SEND: begin
                    uart_wr <= 1'b0;
                    gap     <= 16'(BYTE_CYCLES - 2);
                    state   <= (BYTE_CYCLES > 2) ? GAP : IDLE;
                end
                GAP: if (gap <= 16'd1) begin
                    state <= IDLE;
                    gap   <= '0;
                end else begin
                    gap <= gap - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed stimulus with a scoreboard queue checked by a negedge monitor.
module tb_uart_tx_sched;
    logic       CLK = 1'b0;
    logic       NRST;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       stall;
    logic       full;
    logic [2:0] count;
    logic       busy;
    logic       uart_wr;
    logic [7:0] uart_dat;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         stall_n = 0;
    int         max_cnt = 0;
    logic       prev_wr = 1'b0;
    logic [7:0] exp_q[$];
    int         pulse_q[$];

    uart_tx_sched #(.DEPTH(4), .BYTE_CYCLES(8)) dut (
        .CLK      (CLK),
        .NRST     (NRST),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .stall    (stall),
        .full     (full),
        .count    (count),
        .busy     (busy),
        .uart_wr  (uart_wr),
        .uart_dat (uart_dat)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every strobe pops the oldest expected byte.
    always @(negedge CLK) begin
        if (!NRST) begin
            prev_wr = 1'b0;
        end else begin
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (uart_wr) begin
                pulse_q.push_back(cyc);
                chk("uart_wr_single_cycle", prev_wr, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse got dat=%0h exp=no strobe (cyc %0d)", uart_dat, cyc);
                end else begin
                    chk("uart_dat", uart_dat, exp_q.pop_front());
                end
            end
            prev_wr = uart_wr;
        end
    end

    task automatic push_byte(input logic [7:0] b, output int e);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        wr_en = 1'b1;
        wr_data = b;
        while (!acc && n < 100) begin
            #1;
            acc = !stall;
            if (stall) stall_n++;
            @(posedge CLK);
            n++;
        end
        #1;
        wr_en = 1'b0;
        e = cyc;
        chk("push_accepted", acc, 1);
        if (acc) exp_q.push_back(b);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("wait_idle_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e0, e4, e5;
        NRST = 1'b0;
        wr_en = 1'b0;
        wr_data = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        wr_en = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_uart_wr", uart_wr, 0);
        chk("rst_uart_dat", uart_dat, 8'h00);
        chk("rst_stall", stall, 0);
        wr_en = 1'b0;
        @(posedge CLK);
        #1;
        NRST = 1'b1;
        @(posedge CLK);
        #1;
        chk("idle_uart_wr", uart_wr, 0);

        // single byte
        pulse_q.delete();
        push_byte(8'h41, e);
        chk("single_count", count, 1);
        repeat (7) @(posedge CLK);
        #1;
        chk("single_busy_gap", busy, 1);
        @(posedge CLK);
        #1;
        chk("single_busy_done", busy, 0);
        chk("single_pulses", pulse_q.size(), 1);
        if (pulse_q.size() == 1) chk("single_latency", pulse_q[0], e + 1);

        // burst of four
        pulse_q.delete();
        push_byte(8'h30, e0);
        push_byte(8'h31, e);
        push_byte(8'h32, e);
        chk("burst_push_pop_count", count, 2);
        push_byte(8'h33, e);
        wait_idle();
        chk("burst_pulses", pulse_q.size(), 4);
        foreach (pulse_q[i]) chk("burst_pulse_cycle", pulse_q[i], e0 + 1 + 8 * i);

        // overflow
        pulse_q.delete();
        stall_n = 0;
        max_cnt = 0;
        push_byte(8'h50, e0);
        for (int i = 1; i < 5; i++) push_byte(8'h50 + 8'(i), e4);
        chk("ovf_count_full", count, 4);
        chk("ovf_full", full, 1);
        chk("ovf_fill_edge", e4, e0 + 4);
        push_byte(8'h55, e5);
        chk("ovf_stall_cycles", stall_n, 6);
        chk("ovf_accept_edge", e5, e0 + 11);
        wait_idle();
        chk("ovf_pulses", pulse_q.size(), 6);
        chk("ovf_max_count", max_cnt, 4);

        // wrap-around
        pulse_q.delete();
        for (int i = 0; i < 10; i++) push_byte(8'(i), e);
        wait_idle();
        chk("wrap_pulses", pulse_q.size(), 10);
        chk("wrap_count", count, 0);
        chk("wrap_scoreboard_empty", exp_q.size(), 0);

        // push during SEND
        pulse_q.delete();
        push_byte(8'hBB, e0);
        @(posedge CLK);
        #1;
        chk("send_uart_wr", uart_wr, 1);
        chk("send_count", count, 1);
        push_byte(8'hAA, e);
        chk("send_push_edge", e, e0 + 2);
        chk("send_push_count", count, 1);
        wait_idle();
        chk("send_pulses", pulse_q.size(), 2);
        if (pulse_q.size() == 2) begin
            chk("send_first", pulse_q[0], e0 + 1);
            chk("send_spacing", pulse_q[1] - pulse_q[0], 8);
        end

        // reset mid-GAP
        pulse_q.delete();
        push_byte(8'h60, e0);
        push_byte(8'h61, e);
        push_byte(8'h62, e);
        @(posedge CLK);
        #1;
        NRST = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_uart_wr", uart_wr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_uart_dat", uart_dat, 8'h00);
        repeat (2) @(posedge CLK);
        #1;
        NRST = 1'b1;
        exp_q.delete();
        @(posedge CLK);
        #1;
        chk("postrst_uart_wr", uart_wr, 0);
        chk("postrst_count", count, 0);
        repeat (20) @(posedge CLK);
        #1;
        chk("postrst_no_pulses", pulse_q.size(), 1);
        push_byte(8'h77, e);
        wait_idle();
        chk("postrst_new_pulses", pulse_q.size(), 2);
        if (pulse_q.size() == 2) chk("postrst_new_latency", pulse_q[1], e + 1);

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 16, queue entries (power of two, 2..256).
REQ-002 SHALL have parameter BYTE_CYCLES, default 8680, clocks reserved per transmitted byte (10 bits x 868 clk/bit); legal range 2..65535.
REQ-003 SHALL have port CLK  in  1  system clock, all state on rising edge.
REQ-004 SHALL have port NRST  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port wr_en  in  1  CPU store to UART_ADDR (M stage) this cycle.
REQ-006 SHALL have port wr_data  in  8  byte to transmit (store_dataM[7:0]).
REQ-007 SHALL have port stall  out  1  combinational: wr_en & full; pipeline holds M stage while high.
REQ-008 SHALL have port full  out  1  registered: count == DEPTH.
REQ-009 SHALL have port count  out  $clog2(DEPTH)+1  registered queue occupancy.
REQ-010 SHALL have port busy  out  1  registered: state != IDLE or count != 0.
REQ-011 SHALL have port uart_wr  out  1  registered one-cycle strobe to uart uart_wr_i.
REQ-012 SHALL have port uart_dat  out  8  registered byte to uart uart_dat_i, valid while uart_wr high.

Function
REQ-013 SHALL buffer bytes in a FIFO of DEPTH entries, oldest-first issue, wrap-around pointers modulo DEPTH.
REQ-014 SHALL accept wr_data on a rising edge where wr_en=1 and full=0; count increments by one.
REQ-015 SHALL not write when wr_en=1 and full=1; byte is not lost since stall holds the store, which retries next cycle.
REQ-016 SHALL run FSM states IDLE, SEND, GAP.
REQ-017 IDLE -> SEND when count != 0; stays IDLE when count == 0.
REQ-018 SEND lasts exactly one cycle: uart_wr=1, uart_dat=head byte, head popped at the edge leaving SEND; -> GAP.
REQ-019 GAP loads gap counter with BYTE_CYCLES-2 on entry, decrements each cycle, -> IDLE when counter is 0; consecutive uart_wr rising edges are exactly BYTE_CYCLES cycles apart while queue non-empty.
REQ-020 Latency: write accepted at edge n into empty queue in IDLE -> uart_wr high in the cycle after edge n+1.
REQ-021 Simultaneous push and pop (write accepted during SEND): count unchanged, both pointers advance.
REQ-022 While full, a pop in SEND and a stalled write in the same cycle: write still rejected that cycle (full is registered); accepted next cycle.
REQ-023 uart_wr SHALL be 0 in IDLE and GAP; uart_dat SHALL hold its last value outside SEND.
REQ-024 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-025 NRST=0 SHALL asynchronously force state=IDLE, pointers=0, count=0, gap counter=0, full=0, busy=0, uart_wr=0, uart_dat=8'h00.
REQ-026 Reset mid-GAP or mid-SEND SHALL discard queued bytes; no uart_wr pulse in the first cycle after release.
REQ-027 stall SHALL be 0 during reset regardless of wr_en.

Structure
REQ-028 Shared package SHALL hold FSM state enum (IDLE, SEND, GAP) and the defaults for DEPTH and BYTE_CYCLES beside UART_ADDR.
REQ-029 Storage and pointers SHALL live in one sub-module uart_tx_fifo (push/pop/full/empty/count); uart_tx_sched holds FSM and gap counter.

Verification
REQ-030 Single byte: BYTE_CYCLES=8, write 8'h41 at edge 0 -> uart_wr=1, uart_dat=8'h41 in cycle after edge 1; busy=0 after cycle 9.
REQ-031 Burst: BYTE_CYCLES=8, write 8'h30..8'h33 on 4 consecutive edges -> four uart_wr pulses at cycles 2, 10, 18, 26 carrying 30,31,32,33 in order.
REQ-032 Overflow: DEPTH=4, BYTE_CYCLES=100, hold wr_en 6 cycles with distinct bytes -> stall=1 once count=4; no byte dropped or duplicated; output order matches input.
REQ-033 Wrap-around: DEPTH=4, push/drain 10 bytes 8'h00..8'h09 -> output order 00..09, count returns 0.
REQ-034 Push during SEND: count=1, write 8'hAA in SEND cycle -> count stays 1, 8'hAA sent BYTE_CYCLES later.
REQ-035 Reset mid-GAP: 3 bytes queued, NRST low 2 cycles during GAP -> count=0, uart_wr=0, no further pulses until new write.
